// File: rtl/decode_stage_pkg.sv
// Shared decode constants for the ID stage: opcode patterns, the zero-register
// index and a small instruction classifier used by the immediate and hazard logic.
package lego_pkg;

    localparam int XZR = 31;

    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [6:0]  OP_CB   = 7'b1011010;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;

    typedef enum logic [2:0] {
        IK_OTHER,
        IK_B,
        IK_CB,
        IK_LDUR,
        IK_STUR,
        IK_ALUI
    } ikind_t;

    // Format class of an instruction word; the opcode fields do not overlap.
    function automatic ikind_t classify(input logic [31:0] instr);
        if (instr[31:26] == OP_B)                              return IK_B;
        if (instr[31:25] == OP_CB)                             return IK_CB;
        if (instr[31:21] == OP_LDUR)                           return IK_LDUR;
        if (instr[31:21] == OP_STUR)                           return IK_STUR;
        if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) return IK_ALUI;
        return IK_OTHER;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID inputs, writeback port, hazard output and ID/EX buffer outputs of the decode stage.
interface decode_stage_if #(
    parameter int XLEN   = 64,
    parameter int AW     = 5,
    parameter int CTRL_W = 12
);
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [31:0]       if_instr;
    logic [CTRL_W-1:0] ctrl_in;
    logic              id_stall;
    logic              flush;
    logic              ex_mem_read;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [31:0]       ex_instr;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_rd1;
    logic [XLEN-1:0]   ex_rd2;
    logic [AW-1:0]     ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    // Upstream side: fetch, control unit, EX/WB feedback.
    modport master (
        output if_valid, if_pc, if_instr, ctrl_in, flush, ex_mem_read,
               wb_en, wb_addr, wb_data,
        input  id_stall, ex_valid, ex_pc, ex_instr, ex_imm, ex_rd1, ex_rd2,
               ex_rd, ex_ctrl
    );

    // Decode stage side.
    modport slave (
        input  if_valid, if_pc, if_instr, ctrl_in, flush, ex_mem_read,
               wb_en, wb_addr, wb_data,
        output id_stall, ex_valid, ex_pc, ex_instr, ex_imm, ex_rd1, ex_rd2,
               ex_rd, ex_ctrl
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write register file. The top index is the zero register: it is not
// stored, reads return 0 and writes to it are dropped. A write in the same
// cycle as a read of the same index is forwarded to the read port.
module reg_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    localparam logic [AW-1:0] XZR_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS-1];

    // Write port: commit on posedge unless targeting the zero register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != XZR_IDX) begin
            regs[wa] <= wd;
        end
    end

    // Read port 1: zero register, then writeback bypass, then storage.
    always_comb begin
        rd1 = '0;
        if (ra1 == XZR_IDX)       rd1 = '0;
        else if (we && wa == ra1) rd1 = wd;
        else                      rd1 = regs[ra1];
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = '0;
        if (ra2 == XZR_IDX)       rd2 = '0;
        else if (we && wa == ra2) rd2 = wd;
        else                      rd2 = regs[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined ID stage: reads operands, builds the sign-extended immediate,
// detects load-use hazards and registers everything into the ID/EX buffer.
module decode_stage
    import lego_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 12
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);

    localparam logic [AW-1:0] XZR_IDX = AW'(NREGS - 1);

    ikind_t                  kind_p0;
    logic [AW-1:0]           idx1_p0;
    logic [AW-1:0]           idx2_p0;
    logic                    uses2_p0;
    logic [XLEN-1:0]         rd1_p0;
    logic [XLEN-1:0]         rd2_p0;
    logic signed [XLEN-1:0]  imm_p0;
    logic                    stall_p0;
    logic                    issue_p0;

    logic                    vld_p1;
    logic [XLEN-1:0]         pc_p1;
    logic [31:0]             instr_p1;
    logic signed [XLEN-1:0]  imm_p1;
    logic [XLEN-1:0]         rd1_p1;
    logic [XLEN-1:0]         rd2_p1;
    logic [AW-1:0]           rd_p1;
    logic [CTRL_W-1:0]       ctrl_p1;

    // Unshifted immediate; only ADDI/SUBI are zero-extended.
    function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                                       input ikind_t kind);
        case (kind)
            IK_B:            return XLEN'($signed(instr[25:0]));
            IK_CB:           return XLEN'($signed(instr[23:5]));
            IK_LDUR, IK_STUR: return XLEN'($signed(instr[20:12]));
            IK_ALUI:         return XLEN'(instr[21:10]);
            default:         return '0;
        endcase
    endfunction

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra1 (idx1_p0),
        .ra2 (idx2_p0),
        .rd1 (rd1_p0),
        .rd2 (rd2_p0),
        .we  (bus.wb_en),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

    // Stage p0: field extraction, immediate and load-use hazard.
    always_comb begin
        kind_p0  = classify(bus.if_instr);
        idx1_p0  = AW'(bus.if_instr[9:5]);
        idx2_p0  = (kind_p0 == IK_STUR || kind_p0 == IK_CB) ? AW'(bus.if_instr[4:0])
                                                           : AW'(bus.if_instr[20:16]);
        uses2_p0 = !(kind_p0 == IK_B || kind_p0 == IK_LDUR || kind_p0 == IK_ALUI);
        imm_p0   = gen_imm(bus.if_instr, kind_p0);
        stall_p0 = bus.if_valid && vld_p1 && bus.ex_mem_read && rd_p1 != XZR_IDX &&
                   (rd_p1 == idx1_p0 || (uses2_p0 && rd_p1 == idx2_p0)) && !bus.flush;
        issue_p0 = bus.if_valid && !bus.flush && !stall_p0;
    end

    // Stage p0 -> p1: ID/EX buffer; flush, stall and empty IF/ID all insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= '0;
            imm_p1   <= '0;
            rd1_p1   <= '0;
            rd2_p1   <= '0;
            rd_p1    <= '0;
            ctrl_p1  <= '0;
        end else if (issue_p0) begin
            vld_p1   <= 1'b1;
            pc_p1    <= bus.if_pc;
            instr_p1 <= bus.if_instr;
            imm_p1   <= imm_p0;
            rd1_p1   <= rd1_p0;
            rd2_p1   <= rd2_p0;
            rd_p1    <= AW'(bus.if_instr[4:0]);
            ctrl_p1  <= bus.ctrl_in;
        end else begin
            vld_p1   <= 1'b0;
            ctrl_p1  <= '0;
        end
    end

    assign bus.id_stall = stall_p0;
    assign bus.ex_valid = vld_p1;
    assign bus.ex_pc    = pc_p1;
    assign bus.ex_instr = instr_p1;
    assign bus.ex_imm   = imm_p1;
    assign bus.ex_rd1   = rd1_p1;
    assign bus.ex_rd2   = rd2_p1;
    assign bus.ex_rd    = rd_p1;
    assign bus.ex_ctrl  = ctrl_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: immediate table, hand-written hazard/bypass/reset
// sequences and a randomized run against a behavioural model.
module tb_decode_stage;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int CTRL_W = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .AW(AW), .CTRL_W(CTRL_W)) bus ();

    decode_stage #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .AW     (AW),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: architectural registers plus the expected ID/EX entry.
    logic [63:0] m_regs [32];
    logic        m_valid;
    logic [63:0] m_pc, m_imm, m_rd1, m_rd2;
    logic [31:0] m_instr;
    logic [4:0]  m_rd;
    logic [11:0] m_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
    } imm_vec_t;

    imm_vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
        return {10'h244, imm, rn, rd};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'h458, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_ldur(input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] imm);
        return {11'h7C2, imm, 2'b00, rn, rt};
    endfunction

    // Immediate from the format rules with explicit bit replication.
    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        if (i[31:26] == 6'b000101)                    return {{38{i[25]}}, i[25:0]};
        if (i[31:25] == 7'b1011010)                   return {{45{i[23]}}, i[23:5]};
        if (i[31:21] == 11'h7C2 || i[31:21] == 11'h7C0) return {{55{i[20]}}, i[20:12]};
        if (i[31:22] == 10'h244 || i[31:22] == 10'h344) return {52'd0, i[21:10]};
        return 64'd0;
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 32; k++) m_regs[k] = 64'd0;
        m_valid = 1'b0; m_pc = '0; m_imm = '0; m_rd1 = '0; m_rd2 = '0;
        m_instr = '0; m_rd = '0; m_ctrl = '0;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic fl, input logic mr,
                         input logic we, input logic [4:0] wa, input logic [63:0] wd);
        bus.if_valid    = v;
        bus.if_pc       = {$urandom, $urandom};
        bus.if_instr    = instr;
        bus.ctrl_in     = 12'($urandom);
        bus.flush       = fl;
        bus.ex_mem_read = mr;
        bus.wb_en       = we;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
    endtask

    // One clock: check the hazard output, predict the ID/EX entry, clock, compare.
    task automatic step();
        logic [31:0] i;
        logic [4:0]  idx1, idx2;
        logic        is_b, is_cb, is_ld, is_st, is_alui, uses2, exp_stall;
        #1;
        i       = bus.if_instr;
        is_b    = (i[31:26] == 6'b000101);
        is_cb   = (i[31:25] == 7'b1011010);
        is_ld   = (i[31:21] == 11'h7C2);
        is_st   = (i[31:21] == 11'h7C0);
        is_alui = (i[31:22] == 10'h244 || i[31:22] == 10'h344);
        idx1    = i[9:5];
        idx2    = (is_st || is_cb) ? i[4:0] : i[20:16];
        uses2   = !(is_b || is_ld || is_alui);
        exp_stall = bus.if_valid && m_valid && bus.ex_mem_read && m_rd != 5'd31 &&
                    (m_rd == idx1 || (uses2 && m_rd == idx2)) && !bus.flush;
        check("id_stall", bus.id_stall, exp_stall);
        if (bus.if_valid && !bus.flush && !exp_stall) begin
            m_valid = 1'b1;
            m_pc    = bus.if_pc;
            m_instr = i;
            m_imm   = ref_imm(i);
            m_rd1   = ref_read(idx1);
            m_rd2   = ref_read(idx2);
            m_rd    = i[4:0];
            m_ctrl  = bus.ctrl_in;
        end else begin
            m_valid = 1'b0;
            m_ctrl  = '0;
        end
        if (bus.wb_en && bus.wb_addr != 5'd31) m_regs[bus.wb_addr] = bus.wb_data;
        @(posedge clk);
        #1;
        check("ex_valid", bus.ex_valid, m_valid);
        check("ex_ctrl", bus.ex_ctrl, m_ctrl);
        if (m_valid) begin
            check("ex_pc", bus.ex_pc, m_pc);
            check("ex_instr", bus.ex_instr, m_instr);
            check("ex_imm", bus.ex_imm, m_imm);
            check("ex_rd1", bus.ex_rd1, m_rd1);
            check("ex_rd2", bus.ex_rd2, m_rd2);
            check("ex_rd", bus.ex_rd, m_rd);
        end
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: w = {6'b000101, w[25:0]};
            1: w = {7'b1011010, w[24:5], rnd_reg()};
            2: w = {11'h7C2, w[20:10], rnd_reg(), rnd_reg()};
            3: w = {11'h7C0, w[20:10], rnd_reg(), rnd_reg()};
            4: w = {10'h244, w[21:10], rnd_reg(), rnd_reg()};
            5: w = {10'h344, w[21:10], rnd_reg(), rnd_reg()};
            default: w = enc_add(rnd_reg(), rnd_reg(), rnd_reg());
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ {6'b000101, 26'h3FFFFFF},            64'hFFFF_FFFF_FFFF_FFFF };
        vecs[1] = '{ {8'hB4, 19'h40000, 5'd1},            64'hFFFF_FFFF_FFFC_0000 };
        vecs[2] = '{ {6'b000101, 26'h0000010},            64'h0000_0000_0000_0010 };
        vecs[3] = '{ {8'hB5, 19'h00003, 5'd2},            64'h0000_0000_0000_0003 };
        vecs[4] = '{ {11'h7C2, 9'h1FF, 2'b00, 5'd1, 5'd2}, 64'hFFFF_FFFF_FFFF_FFFF };
        vecs[5] = '{ {11'h7C0, 9'h0FF, 2'b00, 5'd1, 5'd2}, 64'h0000_0000_0000_00FF };
        vecs[6] = '{ {10'h244, 12'hFFF, 5'd1, 5'd2},       64'h0000_0000_0000_0FFF };
        vecs[7] = '{ {10'h344, 12'h800, 5'd1, 5'd2},       64'h0000_0000_0000_0800 };
        vecs[8] = '{ {11'h458, 5'd3, 6'h3F, 5'd1, 5'd2},   64'h0000_0000_0000_0000 };

        // Reset state
        rst = 1'b1;
        drive(0, 32'd0, 0, 0, 0, 5'd0, 64'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", bus.ex_valid, 1'b0);
        check("rst_ex_pc", bus.ex_pc, 64'd0);
        check("rst_ex_ctrl", bus.ex_ctrl, 12'd0);
        check("rst_ex_imm", bus.ex_imm, 64'd0);
        check("rst_id_stall", bus.id_stall, 1'b0);
        rst = 1'b0;

        // ADDI X1,X2,#5 with X2 = 7
        drive(0, 32'd0, 0, 0, 1, 5'd2, 64'd7);
        step();
        drive(1, enc_addi(5'd1, 5'd2, 12'd5), 0, 0, 0, 5'd0, 64'd0);
        step();
        check("addi_rd1", bus.ex_rd1, 64'd7);
        check("addi_imm", bus.ex_imm, 64'd5);
        check("addi_rd", bus.ex_rd, 5'd1);
        check("addi_valid", bus.ex_valid, 1'b1);

        // Same-cycle writeback bypass, then XZR write dropped
        drive(1, enc_add(5'd7, 5'd3, 5'd0), 0, 0, 1, 5'd3, 64'hDEAD);
        step();
        check("bypass_rd1", bus.ex_rd1, 64'hDEAD);
        drive(0, 32'd0, 0, 0, 1, 5'd31, 64'h1234);
        step();
        drive(1, enc_add(5'd8, 5'd31, 5'd3), 0, 0, 0, 5'd0, 64'd0);
        step();
        check("xzr_rd1", bus.ex_rd1, 64'd0);
        check("x3_rd2", bus.ex_rd2, 64'hDEAD);

        // Immediate table
        for (int k = 0; k < 9; k++) begin
            drive(1, vecs[k].instr, 0, 0, 0, 5'd0, 64'd0);
            step();
            check("imm_tbl", bus.ex_imm, vecs[k].imm);
        end

        // Load-use: LDUR X4 then ADD X5,X4,X6 -> one bubble, then issue
        drive(1, enc_ldur(5'd4, 5'd9, 9'd0), 0, 0, 0, 5'd0, 64'd0);
        step();
        drive(1, enc_add(5'd5, 5'd4, 5'd6), 0, 1, 0, 5'd0, 64'd0);
        #1;
        check("lu_stall", bus.id_stall, 1'b1);
        step();
        check("lu_bubble", bus.ex_valid, 1'b0);
        check("lu_bubble_ctrl", bus.ex_ctrl, 12'd0);
        drive(1, enc_add(5'd5, 5'd4, 5'd6), 0, 0, 0, 5'd0, 64'd0);
        #1;
        check("lu_release", bus.id_stall, 1'b0);
        step();
        check("lu_issue", bus.ex_valid, 1'b1);
        check("lu_issue_rd", bus.ex_rd, 5'd5);

        // Flush and load-use hazard in the same cycle
        drive(1, enc_ldur(5'd4, 5'd9, 9'd0), 0, 0, 0, 5'd0, 64'd0);
        step();
        drive(1, enc_add(5'd5, 5'd6, 5'd4), 1, 1, 0, 5'd0, 64'd0);
        #1;
        check("fl_stall", bus.id_stall, 1'b0);
        step();
        check("fl_valid", bus.ex_valid, 1'b0);

        // Asynchronous reset mid-run
        drive(1, enc_add(5'd9, 5'd2, 5'd3), 0, 0, 0, 5'd0, 64'd0);
        step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.ex_valid, 1'b0);
        check("mid_rst_rd1", bus.ex_rd1, 64'd0);
        check("mid_rst_pc", bus.ex_pc, 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, enc_add(5'd0, 5'd2, 5'd3), 0, 0, 0, 5'd0, 64'd0);
        step();
        check("post_rst_x2", bus.ex_rd1, 64'd0);
        check("post_rst_x3", bus.ex_rd2, 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7) != 0, rnd_instr(), $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_reg(),
                  {$urandom, $urandom});
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
